// File: rtl/mem_access_ctrl_if.sv
// Bus bundle for mem_access_ctrl: requester handshake, response channel,
// external ALU operands/result and the byte-wide memory port.
// The controller connects through the slave modport; the master modport is
// the view of whoever plays requester, ALU and memory around it.
interface mem_access_ctrl_if;

  // Request channel
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_base;
  logic [31:0] req_offset;
  logic [31:0] req_wdata;

  // Response channel
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  // External combinational ALU
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_control;
  logic [31:0] alu_result;

  // Byte-wide memory
  logic [15:0] mem_address;
  logic [7:0]  mem_write_data;
  logic        mem_write_enable;
  logic [7:0]  mem_read_data;

  modport master (
    output req_valid, req_write, req_base, req_offset, req_wdata,
    input  req_ready,
    input  resp_valid, resp_rdata, resp_err,
    output resp_ready,
    input  alu_a, alu_b, alu_control,
    output alu_result,
    input  mem_address, mem_write_data, mem_write_enable,
    output mem_read_data
  );

  modport slave (
    input  req_valid, req_write, req_base, req_offset, req_wdata,
    output req_ready,
    output resp_valid, resp_rdata, resp_err,
    input  resp_ready,
    output alu_a, alu_b, alu_control,
    input  alu_result,
    output mem_address, mem_write_data, mem_write_enable,
    input  mem_read_data
  );

endinterface

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: turns one 32-bit word load/store request into an address
// computation on an external ALU followed by four little-endian byte
// transfers on a byte-wide memory, then presents a response.
// Sequence per request: IDLE (accept) -> ADDR (1 cycle) -> XFER (4 beats)
// -> RESP (until resp_ready).
// Optional feature: define MEM_ACCESS_BOUNDS_CHECK_EN to reject effective
// addresses above 16'hFFFC (or with nonzero upper half); such requests skip
// XFER and answer with resp_err=1. Without it, addresses wrap modulo 2^16.
module mem_access_ctrl (
  input logic         clk,
  input logic         rst,
  mem_access_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    XFER = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b010;

  state_t state_q, state_d;

  // Registered copy of the accepted request
  logic        write_q,  write_d;
  logic [31:0] base_q,   base_d;
  logic [31:0] offset_q, offset_d;
  logic [31:0] wdata_q,  wdata_d;

  // Effective address, beat counter and assembled load data
  logic [15:0] ea_q,     ea_d;
  logic [1:0]  beat_q,   beat_d;
  logic [31:0] rdata_q,  rdata_d;

`ifdef MEM_ACCESS_BOUNDS_CHECK_EN
  logic err_q, err_d;
  logic addr_fault;

  // A word access must fit entirely inside the 64 KiB space
  assign addr_fault = (bus.alu_result[31:16] != 16'h0000) ||
                      (bus.alu_result[15:0] > 16'hFFFC);
`else
  logic unused_alu_hi;

  // Upper half of the sum is discarded when addresses simply wrap
  assign unused_alu_hi = ^bus.alu_result[31:16];
`endif

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      write_q  <= 1'b0;
      base_q   <= '0;
      offset_q <= '0;
      wdata_q  <= '0;
      ea_q     <= '0;
      beat_q   <= '0;
      rdata_q  <= '0;
`ifdef MEM_ACCESS_BOUNDS_CHECK_EN
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      write_q  <= write_d;
      base_q   <= base_d;
      offset_q <= offset_d;
      wdata_q  <= wdata_d;
      ea_q     <= ea_d;
      beat_q   <= beat_d;
      rdata_q  <= rdata_d;
`ifdef MEM_ACCESS_BOUNDS_CHECK_EN
      err_q    <= err_d;
`endif
    end
  end

  // Next-state logic: one request at a time, four beats, hold until accepted
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          state_d = ADDR;
        end
      end
      ADDR: begin
`ifdef MEM_ACCESS_BOUNDS_CHECK_EN
        state_d = addr_fault ? RESP : XFER;
`else
        state_d = XFER;
`endif
      end
      XFER: begin
        if (beat_q == 2'd3) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (bus.resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath updates: capture request, latch address, step beats, gather bytes
  always_comb begin
    write_d  = write_q;
    base_d   = base_q;
    offset_d = offset_q;
    wdata_d  = wdata_q;
    ea_d     = ea_q;
    beat_d   = beat_q;
    rdata_d  = rdata_q;
`ifdef MEM_ACCESS_BOUNDS_CHECK_EN
    err_d    = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          write_d  = bus.req_write;
          base_d   = bus.req_base;
          offset_d = bus.req_offset;
          wdata_d  = bus.req_wdata;
          rdata_d  = '0;
`ifdef MEM_ACCESS_BOUNDS_CHECK_EN
          err_d    = 1'b0;
`endif
        end
      end
      ADDR: begin
        ea_d   = bus.alu_result[15:0];
        beat_d = 2'd0;
`ifdef MEM_ACCESS_BOUNDS_CHECK_EN
        err_d  = addr_fault;
`endif
      end
      XFER: begin
        beat_d = beat_q + 2'd1;
        if (!write_q) begin
          rdata_d[{beat_q, 3'b000} +: 8] = bus.mem_read_data;
        end
      end
      default: begin
      end
    endcase
  end

  // Outputs decoded from the current state; idle values everywhere else
  always_comb begin
    bus.req_ready        = (state_q == IDLE);
    bus.resp_valid       = (state_q == RESP);
    bus.resp_rdata       = rdata_q;
`ifdef MEM_ACCESS_BOUNDS_CHECK_EN
    bus.resp_err         = err_q;
`else
    bus.resp_err         = 1'b0;
`endif
    bus.alu_a            = '0;
    bus.alu_b            = '0;
    bus.alu_control      = ALU_ADD;
    bus.mem_address      = '0;
    bus.mem_write_data   = '0;
    bus.mem_write_enable = 1'b0;
    case (state_q)
      ADDR: begin
        bus.alu_a = base_q;
        bus.alu_b = offset_q;
      end
      XFER: begin
        bus.mem_address = ea_q + {14'b0, beat_q};
        if (write_q) begin
          bus.mem_write_enable = 1'b1;
          bus.mem_write_data   = wdata_q[{beat_q, 3'b000} +: 8];
        end
      end
      default: begin
      end
    endcase
  end

endmodule
